// File: rtl/udp_rec_burst_ctrl.sv
// Moves fixed-length bursts from the UDP receive cache FIFO to the frame-buffer writer.
// A 2-entry skid buffer absorbs the 1-cycle FIFO read latency so that wr_ready can stall freely.
module udp_rec_burst_ctrl #(
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 1024,
    parameter int ADDR_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_ready,
    output logic              fifo_rd_en,
    input  logic [15:0]       fifo_rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_len,
    input  logic              wr_ack,
    output logic              wr_valid,
    output logic [15:0]       wr_data,
    output logic              wr_last,
    input  logic              wr_ready,
    output logic              busy,
    output logic              burst_done,
    output logic              frame_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [8:0]        BL9     = 9'(BURST_LEN);
    localparam logic [8:0]        LAST9   = 9'(BURST_LEN - 1);
    localparam logic [ADDR_W:0]   BL_A    = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0]   FRAME_A = (ADDR_W+1)'(FRAME_WORDS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rd_cnt_q, rd_cnt_d;
    logic [8:0]        wr_cnt_q, wr_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        occ_q, occ_d;
    logic [15:0]       buf0_q, buf0_d;
    logic [15:0]       buf1_q, buf1_d;

    logic              pop;
    logic [1:0]        occ_after;
    logic [ADDR_W:0]   addr_sum;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;

        wr_valid  = (occ_q != 2'd0);
        pop       = wr_valid && wr_ready;
        // Occupancy after this edge, counting the word already in flight from the FIFO.
        occ_after = occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
        occ_d     = occ_after;

        fifo_rd_en = (state_q == XFER) && (rd_cnt_q < BL9) && (occ_after <= 2'd1);
        rd_pend_d  = fifo_rd_en;
        if (fifo_rd_en) begin
            rd_cnt_d = rd_cnt_q + 9'd1;
        end

        // buf0 always holds the oldest word; buf1 the next one.
        case ({pop, rd_pend_q})
            2'b01: begin
                if (occ_q == 2'd0) buf0_d = fifo_rd_data;
                else               buf1_d = fifo_rd_data;
            end
            2'b10: begin
                if (occ_q == 2'd2) buf0_d = buf1_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rd_data;
                end
            end
            default: ;
        endcase

        if (pop) begin
            wr_cnt_d = wr_cnt_q + 9'd1;
        end

        addr_sum   = {1'b0, addr_q} + BL_A;
        wr_req     = (state_q == REQ);
        busy       = (state_q != IDLE);
        burst_done = (state_q == DONE);
        frame_done = (state_q == DONE) && (addr_sum == FRAME_A);
        wr_last    = wr_valid && (wr_cnt_q == LAST9);

        case (state_q)
            IDLE: begin
                if (fifo_ready) state_d = REQ;
            end
            REQ: begin
                if (wr_ack) begin
                    state_d  = XFER;
                    rd_cnt_d = 9'd0;
                    wr_cnt_d = 9'd0;
                end
            end
            XFER: begin
                if (pop && (wr_cnt_q == LAST9)) state_d = DONE;
            end
            DONE: begin
                addr_d  = (addr_sum == FRAME_A) ? '0 : addr_sum[ADDR_W-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_addr = addr_q;
    assign wr_len  = BL9;
    assign wr_data = buf0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            occ_q     <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_pend_q <= rd_pend_d;
            occ_q     <= occ_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
        end
    end

endmodule

// File: tb/tb_udp_rec_burst_ctrl.sv
// Directed bench for udp_rec_burst_ctrl (BURST_LEN=4, FRAME_WORDS=8) with a FIFO model
// and a scoreboard queue of expected output words.
module tb_udp_rec_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        fifo_ready;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [8:0]  wr_len;
    logic        wr_ack;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic        busy;
    logic        burst_done;
    logic        frame_done;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          burst_rd  = 0;
    int          rd_total  = 0;
    int          acc_total = 0;
    logic        rdy_mode  = 1'b0;

    udp_rec_burst_ctrl #(
        .BURST_LEN  (4),
        .FRAME_WORDS(8),
        .ADDR_W     (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_ready  (fifo_ready),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_len      (wr_len),
        .wr_ack      (wr_ack),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .burst_done  (burst_done),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO read side: data appears one cycle after a sampled read enable.
    initial begin
        logic rd_s;
        fifo_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            rd_s = fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd_s && !rst) begin
                check("fifo_not_overread", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
                else                    fifo_rd_data = 16'hdead;
                burst_rd++;
                rd_total++;
            end
        end
    end

    // Sink ready driver: constant 1, or the repeating pattern 1,0,0,1.
    initial begin
        logic [3:0] pat;
        int         ph;
        pat      = 4'b1001;
        ph       = 0;
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode) begin
                wr_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                wr_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pop on each accepted word, stall and buffer-depth checks.
    initial begin
        int          beat;
        logic        prev_valid;
        logic        prev_ready;
        logic [15:0] prev_data;
        logic [15:0] e;
        beat       = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beat       = 0;
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("stall_valid_held", 32'(wr_valid), 32'd1);
                    check("stall_data_held", 32'(wr_data), 32'(prev_data));
                end
                if (wr_valid) begin
                    check("buffered_le_2", 32'((rd_total - acc_total) <= 2), 32'd1);
                end
                if (wr_valid && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        $display("word data=%04h last=%0b addr=%0h", wr_data, wr_last, wr_addr);
                        check("wr_data", 32'(wr_data), 32'(e));
                        check("wr_last", 32'(wr_last), 32'(beat == 3));
                    end
                    acc_total++;
                    beat = (beat == 3) ? 0 : beat + 1;
                end
                prev_valid = wr_valid;
                prev_ready = wr_ready;
                prev_data  = wr_data;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_req"},     32'(wr_req),     32'd0);
        check({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 32'd0);
        check({tag, "_wr_valid"},   32'(wr_valid),   32'd0);
        check({tag, "_wr_last"},    32'(wr_last),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_burst_done"}, 32'(burst_done), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(wr_data),    32'd0);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        @(negedge clk);
        while (!wr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(wr_req), 32'd1);
    endtask

    task automatic run_burst(input logic [23:0] a, input int ack_d, input logic [15:0] base,
                             input logic exp_frame, input logic drop_rdy, input logic [23:0] a_next);
        int n;
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(base + 16'(i));
            exp_q.push_back(base + 16'(i));
        end
        burst_rd   = 0;
        fifo_ready = 1'b1;
        wait_req();
        check("req_addr", 32'(wr_addr), 32'(a));
        check("req_len",  32'(wr_len),  32'd4);
        for (int i = 1; i < ack_d; i++) begin
            @(posedge clk);
            #2;
            @(negedge clk);
            check("req_held",         32'(wr_req),     32'd1);
            check("req_addr_held",    32'(wr_addr),    32'(a));
            check("req_len_held",     32'(wr_len),     32'd4);
            check("no_rd_before_ack", 32'(fifo_rd_en), 32'd0);
        end
        @(posedge clk);
        #2;
        wr_ack = 1'b1;
        if (drop_rdy) fifo_ready = 1'b0;
        @(posedge clk);
        #2;
        wr_ack = 1'b0;
        if (drop_rdy) begin
            @(posedge clk);
            #2;
            fifo_ready = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!burst_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("burst_done", 32'(burst_done), 32'd1);
        check("frame_done", 32'(frame_done), 32'(exp_frame));
        check("busy_in_done", 32'(busy), 32'd1);
        check("rd_pulses", 32'(burst_rd), 32'd4);
        if (!drop_rdy) fifo_ready = 1'b0;
        @(negedge clk);
        check("done_is_pulse",  32'(burst_done), 32'd0);
        check("frame_is_pulse", 32'(frame_done), 32'd0);
        check("next_addr",      32'(wr_addr),    32'(a_next));
        check("idle_not_busy",  32'(busy),       32'd0);
        check("idle_no_req",    32'(wr_req),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        rst        = 1'b1;
        fifo_ready = 1'b0;
        wr_ack     = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Two bursts through one frame: second wraps the address and flags frame_done.
        run_burst(24'd0, 1, 16'h0001, 1'b0, 1'b0, 24'd4);
        run_burst(24'd4, 1, 16'h0005, 1'b1, 1'b0, 24'd0);

        // Sink ready toggling 1,0,0,1.
        rdy_mode = 1'b1;
        run_burst(24'd0, 1, 16'h0011, 1'b0, 1'b0, 24'd4);
        rdy_mode = 1'b0;

        // Acknowledge delayed by 10 cycles.
        run_burst(24'd4, 10, 16'h0021, 1'b1, 1'b0, 24'd0);

        // Reset after two accepted words of a burst at address 4.
        run_burst(24'd0, 1, 16'h0031, 1'b0, 1'b0, 24'd4);
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(16'h0041 + 16'(i));
            exp_q.push_back(16'h0041 + 16'(i));
        end
        fifo_ready = 1'b1;
        wait_req();
        check("rst_burst_addr", 32'(wr_addr), 32'd4);
        @(posedge clk);
        #2;
        wr_ack = 1'b1;
        @(posedge clk);
        #2;
        wr_ack = 1'b0;
        acc0 = acc_total;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((acc_total - acc0) < 2 && n < 100);
        check("two_accepted_before_rst", 32'(acc_total - acc0), 32'd2);
        @(posedge clk);
        #2;
        rst        = 1'b1;
        fifo_ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midburst_rst");
        rd_total  = 0;
        acc_total = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_burst(24'd0, 1, 16'h0051, 1'b0, 1'b0, 24'd4);

        // fifo_ready dropped during the transfer, high through DONE.
        run_burst(24'd4, 1, 16'h0061, 1'b1, 1'b1, 24'd0);
        @(negedge clk);
        check("req_2_after_done", 32'(wr_req), 32'd1);
        check("req_addr_after_wrap", 32'(wr_addr), 32'd0);
        run_burst(24'd0, 1, 16'h0071, 1'b0, 1'b0, 24'd4);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/udp_rec_burst_ctrl.md
UDP_REC_BURST_CTRL -- requirements
Module: udp_rec_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256, words per burst; legal range 2..256.
REQ-002 SHALL have parameter FRAME_WORDS, default 1024, words per frame buffer; must be an integer multiple of BURST_LEN.
REQ-003 SHALL have parameter ADDR_W, default 24, word-address width.
REQ-004 clk  in  1  single clock, same clock as the read side of the UDP receive cache FIFO; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 fifo_ready  in  1  cache FIFO almost-full flag; high guarantees at least BURST_LEN words are readable.
REQ-007 fifo_rd_en  out  1  cache FIFO read enable.
REQ-008 fifo_rd_data  in  16  cache FIFO read data, valid 1 cycle after fifo_rd_en.
REQ-009 wr_req  out  1  burst request to the frame-buffer writer.
REQ-010 wr_addr  out  ADDR_W  burst start word address.
REQ-011 wr_len  out  9  burst length in words, equal to BURST_LEN.
REQ-012 wr_ack  in  1  request accepted.
REQ-013 wr_valid / wr_data / wr_last  out  1/16/1  per-word data stream; wr_last marks the final word of the burst.
REQ-014 wr_ready  in  1  sink accepts the word when wr_valid and wr_ready are both high.
REQ-015 busy, burst_done, frame_done  out  1 each  status; both done signals are 1-cycle pulses.

Function
REQ-016 FSM SHALL have states IDLE, REQ, XFER and DONE.
REQ-017 IDLE→REQ SHALL occur when fifo_ready=1.
REQ-018 In REQ, wr_req SHALL be held high with wr_addr and wr_len stable until the wr_ack cycle; REQ→XFER SHALL occur on wr_ack.
REQ-019 In XFER, fifo_rd_en SHALL be asserted only when rd_cnt<BURST_LEN and the 2-entry skid buffer will have a free slot for the returned word, accounting for in-flight reads.
REQ-020 Data returned 1 cycle after fifo_rd_en SHALL enter the skid buffer in order; wr_valid SHALL be high whenever the buffer is non-empty.
REQ-021 wr_data SHALL be the oldest buffered word.
REQ-022 wr_data and wr_valid SHALL be held unchanged while wr_valid=1 and wr_ready=0.
REQ-023 wr_last SHALL be high together with wr_valid on the word with wr_cnt=BURST_LEN-1.
REQ-024 Total fifo_rd_en pulses per burst SHALL equal BURST_LEN exactly; no words may be lost or duplicated.
REQ-025 XFER→DONE SHALL occur on the cycle the last word is accepted.
REQ-026 DONE SHALL pulse burst_done for 1 cycle, then go to IDLE.
REQ-027 In DONE, wr_addr SHALL advance by BURST_LEN; when the advanced address equals FRAME_WORDS, it SHALL wrap to 0 and frame_done SHALL pulse in the same cycle as burst_done.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 fifo_ready falling during REQ or XFER SHALL be ignored; the burst always completes.
REQ-030 fifo_ready high in the DONE cycle SHALL NOT skip IDLE; the next wr_req asserts 2 cycles after burst_done.
REQ-031 wr_ack arriving outside REQ SHALL be ignored.
REQ-032 wr_ready held low indefinitely SHALL stall the transfer without any FIFO overread.
REQ-033 rd_cnt and wr_cnt SHALL be 9-bit counters cleared on entry to XFER.

Reset
REQ-034 While rst=1: state=IDLE; wr_addr=0; rd_cnt=0; wr_cnt=0; skid buffer empty; all 1-bit outputs 0; wr_data=0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst immediately; words already read are discarded and wr_addr returns to 0.

Verification (BURST_LEN=4, FRAME_WORDS=8)
REQ-036 fifo_ready=1, wr_ack the cycle after wr_req, wr_ready=1, FIFO words 0x0001..0x0004 -> wr_req with addr 0 and len 4; wr_data 1,2,3,4 with wr_last on 4; exactly 4 fifo_rd_en pulses; burst_done pulse; wr_addr=4.
REQ-037 Second burst with words 5..8 -> addr 4; on completion burst_done and frame_done pulse together; wr_addr=0.
REQ-038 wr_ready toggling 1,0,0,1,... during XFER -> output sequence 1..4 unchanged; no more than 2 words buffered; wr_data stable while stalled.
REQ-039 wr_ack delayed 10 cycles -> wr_req, wr_addr and wr_len stable for 10 cycles; no fifo_rd_en before wr_ack.
REQ-040 rst pulsed after 2 words are accepted -> all outputs 0 next cycle; the following burst starts at addr 0.
REQ-041 fifo_ready dropped in XFER and held high in DONE -> current burst completes; next wr_req appears 2 cycles after burst_done.
